// File: rtl/sd_1011_lane_sched.sv
// Overlapping "1011" detector time-shared across NLANE word requesters.
// Round-robin grant, MSB-first shift, per-lane saved detector context.
module sd_1011_lane_sched #(
  parameter  int NLANE = 4,
  parameter  int W     = 8,
  localparam int LW    = $clog2(NLANE),
  localparam int CW    = $clog2(W+1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NLANE-1:0]   req,
  input  logic [NLANE*W-1:0] word,
  input  logic [NLANE-1:0]   ctx_clr,
  output logic [NLANE-1:0]   ack,
  output logic               PO,
  output logic [LW-1:0]      po_lane,
  output logic               busy,
  output logic               done,
  output logic [LW-1:0]      done_lane,
  output logic [CW-1:0]      match_cnt
);

  typedef enum logic {IDLE, SHIFT} state_t;
  typedef enum logic [1:0] {S0, S1, S10, S101} det_t;

  state_t         state, state_n;
  det_t           ctx [NLANE];
  det_t           work, work_n;
  logic [W-1:0]   shreg;
  logic [W-1:0]   wl [NLANE];
  logic [LW-1:0]  last, g, gnt;
  logic [CW-1:0]  bitn, cnt;
  logic           gnt_ok, hit;
  logic           load, step, fin;

  always_comb begin
    for (int i = 0; i < NLANE; i++)
      wl[i] = word[i*W +: W];
  end

  // search starts just after the previous winner
  always_comb begin
    gnt    = '0;
    gnt_ok = 1'b0;
    for (int k = 1; k <= NLANE; k++) begin
      if (!gnt_ok && req[(int'(last) + k) % NLANE]) begin
        gnt    = LW'((int'(last) + k) % NLANE);
        gnt_ok = 1'b1;
      end
    end
  end

  always_comb begin
    hit    = 1'b0;
    work_n = S0;
    unique case (work)
      S0:   work_n = shreg[W-1] ? S1 : S0;
      S1:   work_n = shreg[W-1] ? S1 : S10;
      S10:  work_n = shreg[W-1] ? S101 : S0;
      S101: begin
        work_n = shreg[W-1] ? S1 : S10;
        hit    = shreg[W-1];
      end
    endcase
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    fin     = 1'b0;
    unique case (state)
      IDLE: begin
        if (gnt_ok) begin
          load    = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (bitn == CW'(W-1)) begin
          fin     = 1'b1;
          state_n = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last      <= LW'(NLANE-1);
      g         <= '0;
      shreg     <= '0;
      work      <= S0;
      bitn      <= '0;
      cnt       <= '0;
      ack       <= '0;
      PO        <= 1'b0;
      po_lane   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_lane <= '0;
      match_cnt <= '0;
      for (int i = 0; i < NLANE; i++)
        ctx[i] <= S0;
    end else begin
      ack  <= '0;
      PO   <= 1'b0;
      done <= 1'b0;
      if (load) begin
        g     <= gnt;
        last  <= gnt;
        shreg <= wl[gnt];
        work  <= ctx[gnt];
        cnt   <= '0;
        bitn  <= '0;
        ack   <= NLANE'(1) << gnt;
        busy  <= 1'b1;
      end
      if (step) begin
        shreg <= shreg << 1;
        work  <= work_n;
        bitn  <= bitn + CW'(1);
        if (hit) begin
          cnt     <= cnt + CW'(1);
          PO      <= 1'b1;
          po_lane <= g;
        end
        if (fin) begin
          busy      <= 1'b0;
          done      <= 1'b1;
          done_lane <= g;
          match_cnt <= cnt + CW'(hit);
          ctx[g]    <= work_n;
        end
      end
      // a clear issued with the write-back overrides it
      for (int i = 0; i < NLANE; i++)
        if (ctx_clr[i]) ctx[i] <= S0;
    end
  end

endmodule
